// File: rtl/mackerel_bus_if.sv
// CPU-side bus bundle for the Mackerel bus controller: address/strobe inputs,
// chip enables and cycle terminations (all strobes active-low).
interface mackerel_bus_if #(
  parameter int ADDR_W    = 22,
  parameter int RAM_BANKS = 4
);
  logic [ADDR_W-16:0]    addr;
  logic [2:0]            a_lo;
  logic [2:0]            fc;
  logic                  as_n;
  logic                  dtack_mfp_n;
  logic                  romen_n;
  logic [RAM_BANKS-1:0]  ramen_n;
  logic                  mfpen_n;
  logic                  iack_mfp_n;
  logic                  dtack_n;
  logic                  vpa_n;
  logic                  berr_n;

  modport master (
    output addr, a_lo, fc, as_n, dtack_mfp_n,
    input  romen_n, ramen_n, mfpen_n, iack_mfp_n, dtack_n, vpa_n, berr_n
  );

  modport slave (
    input  addr, a_lo, fc, as_n, dtack_mfp_n,
    output romen_n, ramen_n, mfpen_n, iack_mfp_n, dtack_n, vpa_n, berr_n
  );
endinterface

// File: rtl/mackerel_bus_ctrl.sv
// Mackerel 68000 bus controller: address decode, boot ROM overlay, wait states,
// IACK/autovector and termination. Define MACKEREL_BERR_EN for BERR + watchdog.
module mackerel_bus_ctrl #(
  parameter int ADDR_W       = 22,
  parameter int RAM_BANKS    = 4,
  parameter int BOOT_CYCLES  = 8,
  parameter int ROM_WAIT     = 1,
  parameter int RAM_WAIT     = 0,
  parameter int MFP_IPL      = 5,
  parameter int BERR_TIMEOUT = 255
) (
  input  logic           clk_i,
  input  logic           rst_i,
  output logic           clk_slow_o,
  mackerel_bus_if.slave  bus
);
  localparam int HI     = ADDR_W - 16;
  localparam int BANK_W = $clog2(RAM_BANKS);
  localparam logic [2:0] MFP_LVL = 3'(MFP_IPL);

  localparam logic [2:0] S_END  = 3'd0;
  localparam logic [2:0] S_IDLE = 3'd1;
  localparam logic [2:0] S_WAIT = 3'd2;
  localparam logic [2:0] S_MFP  = 3'd3;
  localparam logic [2:0] S_ACK  = 3'd4;
  localparam logic [2:0] S_AVEC = 3'd5;
  localparam logic [2:0] S_ERR  = 3'd6;

  logic [2:0] state_q, state_d;
  logic [2:0] wait_q, wait_d;
  logic       iack_q, iack_d;
  logic [3:0] boot_cnt_q, boot_cnt_d;
  logic       boot_q, boot_d;
  logic       clk_slow_q;
  logic       dtack_q, vpa_q, berr_q, iack_mfp_q;
  logic       dtack_d, vpa_d, berr_d, iack_mfp_d;
  logic       wd_expired;

  logic is_iack, iack_lvl_mfp, hit_rom, hit_mfp, hit_ram;
  logic sel_rom, sel_ram, sel_mfp, active, cycle_done;
  logic [BANK_W-1:0] bank;
  logic [RAM_BANKS-1:0] ramen;

  assign is_iack      = (bus.fc == 3'b111);
  assign iack_lvl_mfp = is_iack && (bus.a_lo == MFP_LVL);
  assign hit_rom      = &bus.addr;
  assign hit_mfp      = (&bus.addr[HI:1]) && !bus.addr[0];
  assign hit_ram      = !bus.addr[HI];
  assign bank         = bus.addr[HI-1 -: BANK_W];

  // Until the overlay ends every ordinary cycle lands in ROM
  assign sel_rom = !is_iack && (!boot_q || hit_rom);
  assign sel_ram = !is_iack && boot_q && hit_ram;
  assign sel_mfp = !is_iack && boot_q && hit_mfp;
  assign active  = !bus.as_n && (state_q != S_END);

  always_comb begin
    ramen = '1;
    if (active && sel_ram) ramen[bank] = 1'b0;
  end

  assign bus.romen_n    = !(active && sel_rom);
  assign bus.ramen_n    = ramen;
  assign bus.mfpen_n    = !(active && (sel_mfp || iack_lvl_mfp));
  assign bus.iack_mfp_n = iack_mfp_q;
  assign bus.dtack_n    = dtack_q;
  assign bus.vpa_n      = vpa_q;
  assign bus.berr_n     = berr_q;
  assign clk_slow_o     = clk_slow_q;

`ifdef MACKEREL_BERR_EN
  localparam int WD_W = $clog2(BERR_TIMEOUT + 1);
  logic [WD_W-1:0] wd_q, wd_d;

  assign wd_expired = (wd_q == '0);

  always_comb begin
    wd_d = wd_q;
    if (state_q == S_IDLE && !bus.as_n) wd_d = WD_W'(BERR_TIMEOUT - 1);
    else if ((state_q == S_WAIT || state_q == S_MFP) && wd_q != '0) wd_d = wd_q - 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) wd_q <= '0;
    else       wd_q <= wd_d;
  end
`else
  assign wd_expired = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    iack_d  = iack_q;
    case (state_q)
      S_END:  if (bus.as_n) state_d = S_IDLE;
      S_IDLE: if (!bus.as_n) begin
        iack_d = is_iack;
        if (iack_lvl_mfp)  state_d = S_MFP;
        else if (is_iack)  state_d = S_AVEC;
        else if (sel_rom) begin state_d = S_WAIT; wait_d = 3'(ROM_WAIT); end
        else if (sel_ram) begin state_d = S_WAIT; wait_d = 3'(RAM_WAIT); end
        else if (sel_mfp)  state_d = S_MFP;
`ifdef MACKEREL_BERR_EN
        else               state_d = S_ERR;
`else
        else               state_d = S_END;
`endif
      end
      S_WAIT: begin
        if (bus.as_n)           state_d = S_IDLE;
        else if (wait_q == '0)  state_d = S_ACK;
        else if (wd_expired)    state_d = S_ERR;
        else                    wait_d  = wait_q - 1'b1;
      end
      // MFP acknowledge outranks a watchdog expiring on the same edge
      S_MFP: begin
        if (bus.as_n)             state_d = S_IDLE;
        else if (!bus.dtack_mfp_n) state_d = S_ACK;
        else if (wd_expired)      state_d = S_ERR;
      end
      S_ACK, S_AVEC, S_ERR: if (bus.as_n) state_d = S_IDLE;
      default: state_d = S_END;
    endcase
  end

  assign cycle_done = bus.as_n && (state_q == S_ACK || state_q == S_AVEC || state_q == S_ERR);

  always_comb begin
    boot_d     = boot_q;
    boot_cnt_d = boot_cnt_q;
    if (cycle_done && !boot_q) begin
      if (boot_cnt_q == '0) boot_d = 1'b1;
      else                  boot_cnt_d = boot_cnt_q - 1'b1;
    end
  end

  // VPA and unmapped BERR wait one edge in AVEC/ERR; watchdog BERR is immediate
  assign dtack_d    = !(state_d == S_ACK);
  assign vpa_d      = !(state_d == S_AVEC && state_q == S_AVEC);
`ifdef MACKEREL_BERR_EN
  assign berr_d     = !(state_d == S_ERR && state_q != S_IDLE);
`else
  assign berr_d     = 1'b1;
`endif
  assign iack_mfp_d = !(iack_d && (state_d == S_MFP || state_d == S_ACK));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_END;
      wait_q     <= '0;
      iack_q     <= 1'b0;
      boot_q     <= 1'b0;
      boot_cnt_q <= 4'(BOOT_CYCLES - 1);
      clk_slow_q <= 1'b0;
      dtack_q    <= 1'b1;
      vpa_q      <= 1'b1;
      berr_q     <= 1'b1;
      iack_mfp_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      wait_q     <= wait_d;
      iack_q     <= iack_d;
      boot_q     <= boot_d;
      boot_cnt_q <= boot_cnt_d;
      clk_slow_q <= !clk_slow_q;
      dtack_q    <= dtack_d;
      vpa_q      <= vpa_d;
      berr_q     <= berr_d;
      iack_mfp_q <= iack_mfp_d;
    end
  end
endmodule

// File: tb/tb_mackerel_bus_ctrl.sv
// Directed scoreboard bench for mackerel_bus_ctrl (default parameters).
module tb_mackerel_bus_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clk_slow;
  int   checks = 0;
  int   errors = 0;

  mackerel_bus_if bus ();

  mackerel_bus_ctrl dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .clk_slow_o (clk_slow),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      tag;
    logic [3:0] ramen;
    logic       romen;
    logic       mfpen;
    logic       iack;
    int         dt;
    int         vpa;
    int         berr;
  } exp_t;

  exp_t sb[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // One bus cycle: expectations go in the scoreboard, DUT response is measured
  // in edges after the edge that samples AS low (edge 0), then popped/compared.
  task automatic run(input string tag, input logic [6:0] a, input logic [2:0] lo,
                     input logic [2:0] fc, input int max_e, input int drive_after,
                     input logic [3:0] e_ramen, input logic e_romen, input logic e_mfpen,
                     input logic e_iack, input int e_dt, input int e_vpa, input int e_berr);
    exp_t e;
    logic [3:0] ramen_s;
    logic romen_s, mfpen_s, iack_s;
    logic [3:0] rel;
    int dt, vp, be;
    e.tag = tag; e.ramen = e_ramen; e.romen = e_romen; e.mfpen = e_mfpen;
    e.iack = e_iack; e.dt = e_dt; e.vpa = e_vpa; e.berr = e_berr;
    sb.push_back(e);

    @(negedge clk);
    bus.addr = a; bus.a_lo = lo; bus.fc = fc; bus.as_n = 1'b0;
    #1;
    ramen_s = bus.ramen_n; romen_s = bus.romen_n; mfpen_s = bus.mfpen_n;
    dt = -1; vp = -1; be = -1; iack_s = 1'b1;
    for (int k = 0; k < max_e; k++) begin
      @(posedge clk); #1;
      if (k == 0) iack_s = bus.iack_mfp_n;
      if (!bus.dtack_n) dt = k;
      if (!bus.vpa_n)   vp = k;
      if (!bus.berr_n)  be = k;
      if (dt >= 0 || vp >= 0 || be >= 0) break;
      if (k == drive_after) bus.dtack_mfp_n = 1'b0;
    end
    @(negedge clk);
    bus.as_n = 1'b1; bus.dtack_mfp_n = 1'b1;
    @(posedge clk); #1;
    rel = {bus.dtack_n, bus.vpa_n, bus.berr_n, bus.iack_mfp_n};

    e = sb.pop_front();
    chk({e.tag, ".ramen"}, 32'(ramen_s), 32'(e.ramen));
    chk({e.tag, ".romen"}, 32'(romen_s), 32'(e.romen));
    chk({e.tag, ".mfpen"}, 32'(mfpen_s), 32'(e.mfpen));
    chk({e.tag, ".iack"},  32'(iack_s),  32'(e.iack));
    chk({e.tag, ".dtack_edge"}, dt, e.dt);
    chk({e.tag, ".vpa_edge"},   vp, e.vpa);
    chk({e.tag, ".berr_edge"},  be, e.berr);
    chk({e.tag, ".release"}, 32'(rel), 32'hF);
  endtask

  initial begin
    logic seen_dt, seen_en;
    bus.addr = '0; bus.a_lo = '0; bus.fc = 3'b101; bus.as_n = 1'b1; bus.dtack_mfp_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst.outs", 32'({bus.romen_n, bus.ramen_n, bus.mfpen_n, bus.iack_mfp_n,
                         bus.dtack_n, bus.vpa_n, bus.berr_n}), 32'h3FF);
    chk("rst.clk_slow", 32'(clk_slow), 32'h0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    chk("clk_slow.toggle", 32'(clk_slow), 32'h1);

    // Boot overlay: 8 reads at 0 go to ROM (ROM_WAIT=1 -> DTACK at edge 2)
    for (int i = 0; i < 8; i++)
      run($sformatf("boot%0d", i), 7'h00, 3'd0, 3'b101, 20, -1,
          4'b1111, 1'b0, 1'b1, 1'b1, 2, -1, -1);
    run("ram0",  7'h00, 3'd0, 3'b101, 20, -1, 4'b1110, 1'b1, 1'b1, 1'b1, 1, -1, -1);
    run("ram2",  7'h20, 3'd0, 3'b101, 20, -1, 4'b1011, 1'b1, 1'b1, 1'b1, 1, -1, -1);
    run("ram3",  7'h30, 3'd0, 3'b110, 20, -1, 4'b0111, 1'b1, 1'b1, 1'b1, 1, -1, -1);
    run("rom",   7'h7F, 3'd0, 3'b110, 20, -1, 4'b1111, 1'b0, 1'b1, 1'b1, 2, -1, -1);
    run("iack5", 7'h7F, 3'd5, 3'b111, 20, 2,  4'b1111, 1'b1, 1'b0, 1'b0, 3, -1, -1);
    run("iack2", 7'h7F, 3'd2, 3'b111, 20, -1, 4'b1111, 1'b1, 1'b1, 1'b1, -1, 1, -1);
    run("mfp",   7'h7E, 3'd0, 3'b101, 20, 4,  4'b1111, 1'b1, 1'b0, 1'b1, 5, -1, -1);
`ifdef MACKEREL_BERR_EN
    run("unmap", 7'h40, 3'd0, 3'b101, 20, -1, 4'b1111, 1'b1, 1'b1, 1'b1, -1, -1, 1);
    run("wdog",  7'h7E, 3'd0, 3'b101, 300, -1, 4'b1111, 1'b1, 1'b0, 1'b1, -1, -1, 255);
    run("wdrace", 7'h7E, 3'd0, 3'b101, 300, 254, 4'b1111, 1'b1, 1'b0, 1'b1, 255, -1, -1);
`else
    run("unmap", 7'h40, 3'd0, 3'b101, 20, -1, 4'b1111, 1'b1, 1'b1, 1'b1, -1, -1, -1);
`endif
    run("after", 7'h10, 3'd0, 3'b101, 20, -1, 4'b1101, 1'b1, 1'b1, 1'b1, 1, -1, -1);

    // Reset in the middle of a RAM cycle with AS held low
    @(negedge clk);
    bus.addr = 7'h20; bus.fc = 3'b101; bus.as_n = 1'b0;
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst.outs", 32'({bus.romen_n, bus.ramen_n, bus.mfpen_n, bus.iack_mfp_n,
                            bus.dtack_n, bus.vpa_n, bus.berr_n}), 32'h3FF);
    @(negedge clk); rst = 1'b0;
    seen_dt = 1'b0; seen_en = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      if (!bus.dtack_n) seen_dt = 1'b1;
      if (!bus.romen_n || bus.ramen_n != 4'b1111) seen_en = 1'b1;
    end
    chk("midrst.no_dtack", 32'(seen_dt), 32'h0);
    chk("midrst.no_enable", 32'(seen_en), 32'h0);
    @(negedge clk); bus.as_n = 1'b1;
    @(posedge clk);
    // Overlay is back on: a RAM address now selects ROM
    run("reboot", 7'h20, 3'd0, 3'b101, 20, -1, 4'b1111, 1'b0, 1'b1, 1'b1, 2, -1, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
